serial_operand_serializer: RTL

//   Front end of the bit-serial adder datapath. Accepts two WIDTH-bit operands plus
//   a carry-in over a valid/ready handshake, then streams them LSB-first as one bit

---
 rtl/serial_operand_serializer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/serial_operand_serializer.sv
// Bit-serial adder front end: accepts an operand pair plus carry-in, then streams
// the operands LSB-first one bit pair per clock and closes each frame with adder_clr.
module serial_operand_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             abort,
  output logic             a_bit,
  output logic             b_bit,
  output logic             cin_bit,
  output logic             bit_valid,
  output logic             first_bit,
  output logic             last_bit,
  output logic             adder_clr,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: a pair transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and in_valid is ignored everywhere else.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CLOSE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh_a, sh_b, sh_a_n, sh_b_n;
  logic [CW-1:0]    count, count_n;
  logic             a_n, b_n, cin_n, valid_n, first_n, last_n, clr_n, done_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // State names what the registered outputs show; bit i is on the wires while count==i.
  always_comb begin
    state_n = state;
    sh_a_n  = sh_a;
    sh_b_n  = sh_b;
    count_n = count;
    a_n     = 1'b0;
    b_n     = 1'b0;
    cin_n   = 1'b0;
    valid_n = 1'b0;
    first_n = 1'b0;
    last_n  = 1'b0;
    clr_n   = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = SHIFT;
          sh_a_n  = in_a;
          sh_b_n  = in_b;
          count_n = '0;
          a_n     = in_a[0];
          b_n     = in_b[0];
          cin_n   = in_cin;
          valid_n = 1'b1;
          first_n = 1'b1;
          last_n  = (LAST == '0);
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n = CLOSE;
          clr_n   = 1'b1;
        end else if (count == LAST) begin
          state_n = CLOSE;
          clr_n   = 1'b1;
          done_n  = 1'b1;
        end else begin
          sh_a_n  = sh_a >> 1;
          sh_b_n  = sh_b >> 1;
          count_n = count + CW'(1);
          a_n     = sh_a_n[0];
          b_n     = sh_b_n[0];
          valid_n = 1'b1;
          last_n  = (count_n == LAST);
        end
      end
      CLOSE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_a      <= '0;
      sh_b      <= '0;
      count     <= '0;
      a_bit     <= 1'b0;
      b_bit     <= 1'b0;
      cin_bit   <= 1'b0;
      bit_valid <= 1'b0;
      first_bit <= 1'b0;
      last_bit  <= 1'b0;
      adder_clr <= 1'b0;
      done      <= 1'b0;
    end else begin
      sh_a      <= sh_a_n;
      sh_b      <= sh_b_n;
      count     <= count_n;
      a_bit     <= a_n;
      b_bit     <= b_n;
      cin_bit   <= cin_n;
      bit_valid <= valid_n;
      first_bit <= first_n;
      last_bit  <= last_n;
      adder_clr <= clr_n;
      done      <= done_n;
    end
  end

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

endmodule
